// File: rtl/gsm_mul_pkg.sv
// rtl/gsm_mul_pkg.sv - shared types and widths for the GSM multiplier scheduler
package gsm_mul_pkg;

   localparam int NCH = 3;
   localparam int W0A = 8;
   localparam int W0B = 8;
   localparam int W1A = 16;
   localparam int W1B = 16;
   localparam int W2A = 16;
   localparam int W2B = 8;
   localparam int OPW = 16;

   typedef enum logic [1:0] {IDLE, MUL, DONE} state_e;

   function automatic logic [OPW-1:0] sext8(input logic [7:0] v);
      return {{(OPW-8){v[7]}}, v};
   endfunction

endpackage

// File: rtl/gsm_mul_core.sv
// rtl/gsm_mul_core.sv - combinational 16x16 two's-complement multiplier
module gsm_mul_core
   import gsm_mul_pkg::*;
(
   input  logic signed [OPW-1:0]   a,
   input  logic signed [OPW-1:0]   b,
   output logic signed [2*OPW-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/gsm_mul_sched.sv
// rtl/gsm_mul_sched.sv - round-robin scheduler sharing one multiplier among three GSM product channels
// Per-channel saturating busy counters are added when GSM_MUL_SCHED_CNT_EN is defined.
module gsm_mul_sched
   import gsm_mul_pkg::*;
#(
   parameter int MUL_LAT = 2
`ifdef GSM_MUL_SCHED_CNT_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req,
   input  logic [W0A-1:0] a0,
   input  logic [W0B-1:0] b0,
   input  logic [W1A-1:0] a1,
   input  logic [W1B-1:0] b1,
   input  logic [W2A-1:0] a2,
   input  logic [W2B-1:0] b2,
   output logic [NCH-1:0] gnt,
   output logic [NCH-1:0] vld,
   output logic [15:0]    p0,
   output logic [31:0]    p1,
   output logic [23:0]    p2,
   output logic           busy
`ifdef GSM_MUL_SCHED_CNT_EN
   ,
   output logic [CNT_W-1:0] busy_cnt0,
   output logic [CNT_W-1:0] busy_cnt1,
   output logic [CNT_W-1:0] busy_cnt2
`endif
);

   localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

   state_e             state_q, state_d;
   logic [1:0]         sel_q, sel_d;
   logic [1:0]         last_q, last_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [OPW-1:0]     opa_q, opa_d;
   logic [OPW-1:0]     opb_q, opb_d;
   logic [NCH-1:0]     gnt_q, gnt_d;
   logic [NCH-1:0]     vld_q, vld_d;
   logic [15:0]        p0_q, p0_d;
   logic [31:0]        p1_q, p1_d;
   logic [23:0]        p2_q, p2_d;
   logic signed [2*OPW-1:0] prod;
   logic [1:0]         pick;
   logic [1:0]         cand;
   logic               found;

   gsm_mul_core u_core (
      .a (opa_q),
      .b (opb_q),
      .p (prod)
   );

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      gnt_d   = '0;
      vld_d   = '0;
      p0_d    = p0_q;
      p1_d    = p1_q;
      p2_d    = p2_q;
      found   = 1'b0;
      pick    = '0;
      cand    = '0;

      // Search starts just after the last served channel so every requester gets a turn.
      for (int k = 1; k <= NCH; k++) begin
         cand = 2'((int'(last_q) + k) % NCH);
         if (!found && req[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d   = pick;
               last_d  = pick;
               cnt_d   = CNT_INIT;
               gnt_d   = 3'(3'b001 << pick);
               state_d = MUL;
               case (pick)
                  2'd0: begin
                     opa_d = sext8(a0);
                     opb_d = sext8(b0);
                  end
                  2'd1: begin
                     opa_d = a1;
                     opb_d = b1;
                  end
                  default: begin
                     opa_d = a2;
                     opb_d = sext8(b2);
                  end
               endcase
            end
         end
         MUL: begin
            if (cnt_q == 4'd0) begin
               vld_d   = 3'(3'b001 << sel_q);
               state_d = DONE;
               case (sel_q)
                  2'd0:    p0_d = prod[15:0];
                  2'd1:    p1_d = prod[31:0];
                  default: p2_d = prod[23:0];
               endcase
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sel_q   <= '0;
         last_q  <= 2'd2;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         gnt_q   <= '0;
         vld_q   <= '0;
         p0_q    <= '0;
         p1_q    <= '0;
         p2_q    <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         gnt_q   <= gnt_d;
         vld_q   <= vld_d;
         p0_q    <= p0_d;
         p1_q    <= p1_d;
         p2_q    <= p2_d;
      end
   end

   assign gnt  = gnt_q;
   assign vld  = vld_q;
   assign p0   = p0_q;
   assign p1   = p1_q;
   assign p2   = p2_q;
   assign busy = (state_q != IDLE);

`ifdef GSM_MUL_SCHED_CNT_EN
   logic [CNT_W-1:0] bcnt_q [NCH];
   logic [CNT_W-1:0] bcnt_d [NCH];

   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         bcnt_d[i] = bcnt_q[i];
         if ((req[i] || (state_q != IDLE && sel_q == 2'(i))) && bcnt_q[i] != '1) begin
            bcnt_d[i] = bcnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCH; i++) begin
         if (rst) bcnt_q[i] <= '0;
         else     bcnt_q[i] <= bcnt_d[i];
      end
   end

   assign busy_cnt0 = bcnt_q[0];
   assign busy_cnt1 = bcnt_q[1];
   assign busy_cnt2 = bcnt_q[2];
`endif

endmodule

// File: tb/tb_gsm_mul_sched.sv
// tb/tb_gsm_mul_sched.sv - randomized self-checking bench for gsm_mul_sched against a timeline model
module tb_gsm_mul_sched;

   localparam int MUL_LAT = 2;
   localparam int CNT_W   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req;
   logic [7:0]  a0, b0;
   logic [15:0] a1, b1, a2;
   logic [7:0]  b2;
   logic [2:0]  gnt, vld;
   logic [15:0] p0;
   logic [31:0] p1;
   logic [23:0] p2;
   logic        busy;
`ifdef GSM_MUL_SCHED_CNT_EN
   logic [CNT_W-1:0] busy_cnt0, busy_cnt1, busy_cnt2;
`endif

   always #5 clk = ~clk;

`ifdef GSM_MUL_SCHED_CNT_EN
   gsm_mul_sched #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
`else
   gsm_mul_sched #(.MUL_LAT(MUL_LAT)) dut (
`endif
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .a0   (a0),
      .b0   (b0),
      .a1   (a1),
      .b1   (b1),
      .a2   (a2),
      .b2   (b2),
      .gnt  (gnt),
      .vld  (vld),
      .p0   (p0),
      .p1   (p1),
      .p2   (p2),
      .busy (busy)
`ifdef GSM_MUL_SCHED_CNT_EN
      ,
      .busy_cnt0 (busy_cnt0),
      .busy_cnt1 (busy_cnt1),
      .busy_cnt2 (busy_cnt2)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Timeline model: one product in flight, grant visible after the deciding edge,
   // result MUL_LAT edges later, next decision two edges after that.
   int          edge_n = 0;
   bit          inflight = 0;
   int          op_ch = 0;
   int          op_gnt_edge = 0;
   int          op_vld_edge = 0;
   logic [31:0] op_prod = '0;
   int          m_last = 2;
   logic [31:0] m_p [3] = '{0, 0, 0};
   longint      m_cnt [3] = '{0, 0, 0};

   task automatic model_edge();
      bit     was_busy = inflight;
      int     was_ch = op_ch;
      longint x, y, pr;
      int     ch;
      edge_n++;
      if (rst) begin
         inflight = 0;
         m_last   = 2;
         for (int i = 0; i < 3; i++) begin
            m_p[i]   = '0;
            m_cnt[i] = 0;
         end
         return;
      end
      for (int i = 0; i < 3; i++)
         if ((req[i] || (was_busy && was_ch == i)) && m_cnt[i] < (longint'(1) << CNT_W) - 1)
            m_cnt[i]++;
      if (inflight && edge_n == op_vld_edge) m_p[op_ch] = op_prod;
      if (inflight && edge_n == op_vld_edge + 1) begin
         inflight = 0;
      end else if (!inflight && req != 3'b000) begin
         ch = -1;
         for (int k = 1; k <= 3; k++)
            if (ch < 0 && req[(m_last + k) % 3]) ch = (m_last + k) % 3;
         case (ch)
            0: begin x = longint'($signed(a0)); y = longint'($signed(b0)); end
            1: begin x = longint'($signed(a1)); y = longint'($signed(b1)); end
            default: begin x = longint'($signed(a2)); y = longint'($signed(b2)); end
         endcase
         pr = x * y;
         case (ch)
            0:       op_prod = {16'h0, pr[15:0]};
            1:       op_prod = pr[31:0];
            default: op_prod = {8'h0, pr[23:0]};
         endcase
         op_ch       = ch;
         op_gnt_edge = edge_n;
         op_vld_edge = edge_n + MUL_LAT;
         inflight    = 1;
         m_last      = ch;
      end
   endtask

   task automatic step();
      logic [2:0] eg, ev;
      @(posedge clk);
      model_edge();
      #1;
      eg = (inflight && edge_n == op_gnt_edge) ? 3'(3'b001 << op_ch) : 3'b000;
      ev = (inflight && edge_n == op_vld_edge) ? 3'(3'b001 << op_ch) : 3'b000;
      chk_eq("gnt", 32'(gnt), 32'(eg));
      chk_eq("vld", 32'(vld), 32'(ev));
      chk_eq("busy", 32'(busy), 32'(inflight));
      chk_eq("p0", 32'(p0), m_p[0]);
      chk_eq("p1", p1, m_p[1]);
      chk_eq("p2", 32'(p2), m_p[2]);
`ifdef GSM_MUL_SCHED_CNT_EN
      chk_eq("busy_cnt0", 32'(busy_cnt0), 32'(m_cnt[0]));
      chk_eq("busy_cnt1", 32'(busy_cnt1), 32'(m_cnt[1]));
      chk_eq("busy_cnt2", 32'(busy_cnt2), 32'(m_cnt[2]));
`endif
      @(negedge clk);
   endtask

   task automatic run_op(input logic [2:0] r);
      bit seen = 0;
      req = r;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (gnt != 3'b000) seen = 1;
      end
      if (!seen) chk_eq("gnt_timeout", 32'd0, 32'd1);
      req = 3'b000;
      repeat (MUL_LAT + 3) step();
   endtask

   initial begin
      logic [2:0] gseq [4];
      int         gedge [4];
      logic [2:0] gexp [4];
      int         ng;
      bit         seen;

      gexp = '{3'b001, 3'b010, 3'b100, 3'b001};
      rst = 1'b1; req = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
      @(negedge clk);
      step();
      step();
      chk_eq("rst_busy", 32'(busy), 32'd0);
      chk_eq("rst_p1", p1, 32'd0);
      rst = 1'b0;

`ifdef GSM_MUL_SCHED_CNT_EN
      req = 3'b001;
      repeat (10) step();
      chk_eq("busy_cnt0_10", 32'(busy_cnt0), 32'd10);
      req = 3'b000;
      repeat (MUL_LAT + 3) step();
`endif

      a0 = 8'h80; b0 = 8'h80;
      run_op(3'b001);
      chk_eq("p0_8080", 32'(p0), 32'h4000);
      chk_eq("p1_untouched", p1, 32'h0);
      chk_eq("p2_untouched", 32'(p2), 32'h0);

      a1 = 16'h8000; b1 = 16'h8000;
      run_op(3'b010);
      chk_eq("p1_80008000", p1, 32'h40000000);
      a1 = 16'hFFFF; b1 = 16'h0003;
      run_op(3'b010);
      chk_eq("p1_neg3", p1, 32'hFFFFFFFD);

      a2 = 16'hFFFF; b2 = 8'h7F;
      run_op(3'b100);
      chk_eq("p2_ffff81", 32'(p2), 32'hFFFF81);
      a2 = 16'h7FFF; b2 = 8'h80;
      run_op(3'b100);
      chk_eq("p2_c00080", 32'(p2), 32'hC00080);
      chk_eq("p0_held", 32'(p0), 32'h4000);

      req = 3'b111;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         step();
         if (gnt != 3'b000) begin
            gseq[ng]  = gnt;
            gedge[ng] = edge_n;
            ng++;
         end
      end
      chk_eq("rr_count", 32'(ng), 32'd4);
      for (int i = 0; i < ng; i++) chk_eq("rr_order", 32'(gseq[i]), 32'(gexp[i]));
      for (int i = 1; i < ng; i++) chk_eq("rr_spacing", 32'(gedge[i] - gedge[i-1]), 32'(MUL_LAT + 2));

      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
         step();
         if (gnt == 3'b010) seen = 1;
      end
      chk_eq("gnt_ch1_seen", 32'(seen), 32'd1);
      req = 3'b000;
      step();
      rst = 1'b1;
      step();
      chk_eq("abort_p1", p1, 32'h0);
      chk_eq("abort_busy", 32'(busy), 32'd0);
      chk_eq("abort_vld", 32'(vld), 32'd0);
      rst = 1'b0;
      req = 3'b111;
      step();
      chk_eq("after_rst_gnt", 32'(gnt), 32'b001);
      req = 3'b000;
      repeat (MUL_LAT + 3) step();

      for (int c = 0; c < 600; c++) begin
         req = 3'($urandom_range(0, 7));
         a0 = 8'($urandom);  b0 = 8'($urandom);
         a1 = 16'($urandom); b1 = 16'($urandom);
         a2 = 16'($urandom); b2 = 8'($urandom);
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0;
      req = 3'b000;
      repeat (MUL_LAT + 3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
